// File: rtl/mult_bcd_convert.sv
// rtl/mult_bcd_convert.sv - sequential double-dabble converter from multiplier product to three BCD digits
// Optional leading-zero blanking is enabled by defining BCD_BLANK_EN.
module mult_bcd_convert #(
    parameter int PRODUCT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODUCT_W-1:0] product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           bcd_hund,
    output logic [3:0]           bcd_tens,
    output logic [3:0]           bcd_ones,
    output logic                 busy
);

    localparam int CNT_W = $clog2(PRODUCT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PRODUCT_W-1:0] shreg;
    logic [11:0]          scratch;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 last_shift;
    logic [11:0]          corrected;
    logic [11:0]          scratch_shifted;
    logic [3:0]           hund_raw;
    logic [3:0]           tens_raw;
    logic [3:0]           ones_raw;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign accept     = in_valid && in_ready;
    assign last_shift = (cnt == CNT_W'(1));

    // Correct all digits first, then shift the product MSB into the ones digit.
    always_comb begin
        corrected       = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        scratch_shifted = 12'({corrected, shreg[PRODUCT_W-1]});
        hund_raw        = scratch_shifted[11:8];
        tens_raw        = scratch_shifted[7:4];
        ones_raw        = scratch_shifted[3:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            shreg     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd_hund  <= 4'h0;
            bcd_tens  <= 4'h0;
            bcd_ones  <= 4'h0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next == SHIFT);
            if (state == IDLE && accept) begin
                shreg   <= product;
                scratch <= '0;
                cnt     <= CNT_W'(PRODUCT_W);
            end else if (state == SHIFT) begin
                shreg   <= shreg << 1;
                scratch <= scratch_shifted;
                cnt     <= cnt - CNT_W'(1);
                if (last_shift) begin
`ifdef BCD_BLANK_EN
                    bcd_hund <= (hund_raw == 4'd0) ? 4'hF : hund_raw;
                    bcd_tens <= (hund_raw == 4'd0 && tens_raw == 4'd0) ? 4'hF : tens_raw;
`else
                    bcd_hund <= hund_raw;
                    bcd_tens <= tens_raw;
`endif
                    bcd_ones <= ones_raw;
                end
            end
        end
    end

endmodule
